irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Prioritised interrupt controller that feeds the `irq` input of the Beta decode unit and is sequenced by its `interrupt` output.
- Synchronises and edge-detects up to NSRC peripheral lines (physics timer, laser galvo, UART, ...) and latches them as pending.
- Applies a software mask and presents one active request at a time.
- Tracks in-service state until software writes end-of-interrupt (EOI) through a memory-mapped register window.

Parameters:
NSRC, 8, number of interrupt sources (1..32)
IDW, 3, width of source index, ceil(log2(NSRC)), minimum 1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; all state cleared while low
src  input  NSRC  raw asynchronous interrupt request lines, rising-edge triggered
int_taken  input  1  decode's `interrupt` output: CPU is vectoring this cycle
wr_en  input  1  register write strobe, one cycle per write
wr_addr  input  2  register select for writes
wr_data  input  32  write data
rd_addr  input  2  register select for reads
rd_data  output  32  read data, combinational from rd_addr and registers
irq  output  1  request to decode unit
irq_id  output  IDW  index of the currently presented/served source

Behaviour:
- Register map:
  - 0 MASK: R/W, bit i enables src[i]; reset 0.
  - 1 PENDING: read; write-1-to-clear.
  - 2 EOI: write any value clears in_service; reads as 0.
  - 3 STATUS: read-only, {in_service at bit 31, irq at bit 30, cur_id in low IDW bits}.
  - Bits at or above NSRC read 0 and ignore writes.
- Synchroniser:
  - 2-flop sync per source (s1, s2), plus a prev flop.
  - edge[i] = s2[i] & ~prev[i].
  - A src rising edge first sampled at clock edge N gives pending set at edge N+2.
- Pending:
  - pending[i] sets on edge[i] regardless of MASK; masking only gates presentation.
  - Same-cycle edge[i] and write-1-to-clear of bit i: set wins.
  - Same-cycle edge[i] and acceptance clear of bit i: set wins (new event re-pends).
- Presentation:
  - active = pending & MASK.
  - irq = |active & ~in_service, combinational from registers only.
  - irq_id = lowest set index of active while irq is high, else cur_id.
- Acceptance, on a clock edge with int_taken=1 and irq=1:
  - pending[irq_id] cleared.
  - cur_id <= irq_id.
  - in_service <= 1.
  - irq is low from the next cycle on.
- int_taken while irq=0 is ignored: no state change.
- EOI:
  - A write to address 2 clears in_service at the next edge.
  - irq may reassert the cycle after if active is nonzero.
  - EOI with in_service=0 has no effect.
- FSM, 2 states:
  - IDLE (in_service=0): goes to SERVING on acceptance.
  - SERVING: goes to IDLE on EOI write. A same-cycle acceptance is impossible, because irq=0 in SERVING.
- Reset:
  - While reset is low, all flops are 0: s1, s2, prev, pending, MASK, cur_id, in_service.
  - Outputs: irq=0, irq_id=0, rd_data reflects zeroed registers.
  - Reset asserted mid-service discards pending and in_service.
  - A src line held high across reset release sees prev=0 only after s2 rises, so it yields exactly one edge. This is intentional.
- MASK write while in SERVING only affects the next presentation; cur_id is unchanged.

Test Plan:
- Reset low then high, src=0 -> irq=0, irq_id=0, reads of addr 0..3 all return 0.
- MASK=0x05; pulse src[2] high for 1 cycle at edge N -> PENDING=0x04 at N+2, irq=1, irq_id=2; assert int_taken one cycle -> irq=0, STATUS=0x80000002, PENDING=0.
- MASK=0xFF; src[5] and src[1] rise same cycle -> irq_id=1. int_taken -> irq low while in_service. EOI write -> irq=1, irq_id=5 the following cycle.
- MASK=0x00; pulse src[3] -> PENDING=0x08, irq stays 0. Write MASK=0x08 -> irq=1 next cycle. Write PENDING=0x08 (W1C) -> irq=0.
- Edge on src[0] coinciding with W1C of bit 0, and separately with acceptance of id 0 -> PENDING bit 0 remains 1 in both cases.
- Assert reset low while in_service=1 with PENDING=0x30 -> all state 0 asynchronously. int_taken with irq=0 after release -> no state change.

Source files
------------

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: synchronises and edge-detects the source lines, latches them as pending,
// and presents the lowest-numbered unmasked source to the decode unit. Software services it through a 4-word register window.
module irq_ctrl #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            int_taken,
    input  logic            wr_en,
    input  logic [1:0]      wr_addr,
    input  logic [31:0]     wr_data,
    input  logic [1:0]      rd_addr,
    output logic [31:0]     rd_data,
    output logic            irq,
    output logic [IDW-1:0]  irq_id
);

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_EOI     = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVING = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] s1_q, s1_d;
    logic [NSRC-1:0] s2_q, s2_d;
    logic [NSRC-1:0] prev_q, prev_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;

    logic [NSRC-1:0] edge_det;
    logic [NSRC-1:0] active;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] accept_clr;
    logic [IDW-1:0]  low_id;
    logic            in_service;
    logic            accept;
    logic            eoi_wr;
    logic            unused_wr_bits;

    // Upper write-data bits only matter for wide configurations; fold them so every bit is consumed.
    assign unused_wr_bits = ^wr_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            cur_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cur_id_q  <= cur_id_d;
        end
    end

    always_comb begin
        s1_d     = src;
        s2_d     = s1_q;
        prev_d   = s2_q;
        edge_det = s2_q & ~prev_q;
    end

    assign in_service = (state_q == SERVING);
    assign active     = pending_q & mask_q;
    assign irq        = (|active) & ~in_service;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        low_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                low_id = IDW'(i);
            end
        end
    end

    assign irq_id = irq ? low_id : cur_id_q;
    assign accept = int_taken & irq;
    assign eoi_wr = wr_en && (wr_addr == ADDR_EOI);

    always_comb begin
        w1c    = '0;
        mask_d = mask_q;
        if (wr_en && (wr_addr == ADDR_MASK)) begin
            mask_d = wr_data[NSRC-1:0];
        end
        if (wr_en && (wr_addr == ADDR_PENDING)) begin
            w1c = wr_data[NSRC-1:0];
        end
    end

    always_comb begin
        accept_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            accept_clr[i] = accept && (low_id == IDW'(i));
        end
    end

    // Clears are applied first so a same-cycle edge re-pends the source.
    always_comb begin
        pending_d = (pending_q & ~w1c & ~accept_clr) | edge_det;
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = SERVING;
                    cur_id_d = low_id;
                end
            end
            SERVING: begin
                if (eoi_wr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_MASK:    rd_data[NSRC-1:0] = mask_q;
            ADDR_PENDING: rd_data[NSRC-1:0] = pending_q;
            ADDR_EOI:     rd_data = '0;
            ADDR_STATUS: begin
                rd_data[31]       = in_service;
                rd_data[30]       = irq;
                rd_data[IDW-1:0]  = cur_id_q;
            end
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a behavioural model compared every cycle, plus literal expectations at
// the key points of each scenario.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  srcDrv = '0;
    logic        intTaken = 1'b0;
    logic        wrEn = 1'b0;
    logic [1:0]  wrAddr = '0;
    logic [31:0] wrData = '0;
    logic [1:0]  rdAddr = '0;
    logic [31:0] rd_data;
    logic        irq;
    logic [2:0]  irq_id;

    int compared = 0;
    int mismatched = 0;

    irq_ctrl #(.NSRC(8), .IDW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (srcDrv),
        .int_taken (intTaken),
        .wr_en     (wrEn),
        .wr_addr   (wrAddr),
        .wr_data   (wrData),
        .rd_addr   (rdAddr),
        .rd_data   (rd_data),
        .irq       (irq),
        .irq_id    (irq_id)
    );

    always #5 clk = ~clk;

    // Model state: src samples from 1, 2 and 3 edges ago stand in for the synchroniser latency.
    logic [7:0] mMask = '0, mPend = '0;
    logic [7:0] hist0 = '0, hist1 = '0, hist2 = '0;
    logic [2:0] mCur = '0;
    logic       mInSvc = 1'b0;

    function automatic int lowestIdx(input logic [7:0] a);
        logic [7:0] iso;
        iso = a & (~a + 8'd1);
        return $clog2(iso);
    endfunction

    function automatic logic mIrq();
        return (|(mPend & mMask)) && !mInSvc;
    endfunction

    function automatic int mId();
        return mIrq() ? lowestIdx(mPend & mMask) : int'(mCur);
    endfunction

    function automatic logic [31:0] mRead(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, mMask};
            2'd1:    return {24'd0, mPend};
            2'd3:    return {mInSvc, mIrq(), 27'd0, mCur};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [7:0] edges;
        logic       takeNow, eoiNow;
        int         id;
        if (!reset) begin
            mMask = '0; mPend = '0; mCur = '0; mInSvc = 1'b0;
            hist0 = '0; hist1 = '0; hist2 = '0;
        end else begin
            edges   = hist1 & ~hist2;
            takeNow = intTaken && mIrq();
            id      = mId();
            eoiNow  = wrEn && wrAddr == 2'd2 && mInSvc;
            if (wrEn && wrAddr == 2'd0) mMask = wrData[7:0];
            if (wrEn && wrAddr == 2'd1) mPend = mPend & ~wrData[7:0];
            if (eoiNow) mInSvc = 1'b0;
            if (takeNow) begin
                mPend[id] = 1'b0;
                mCur      = 3'(id);
                mInSvc    = 1'b1;
            end
            mPend = mPend | edges;
            hist2 = hist1; hist1 = hist0; hist0 = srcDrv;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_irq", 32'(irq), 32'(mIrq()));
        checkOutput("model_irq_id", 32'(irq_id), 32'(mId()));
        checkOutput("model_rd_data", rd_data, mRead(rdAddr));
    end

    task automatic applyStimulus(input logic [7:0] s, input logic it, input logic we,
                                 input logic [1:0] wa, input logic [31:0] wd);
        srcDrv = s; intTaken = it; wrEn = we; wrAddr = wa; wrData = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(8'h00, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(8'h00, 1'b0, 1'b1, a, d);
    endtask

    task automatic pulse(input logic [7:0] s);
        applyStimulus(s, 1'b0, 1'b0, 2'd0, 32'd0);
        idle();
        idle();
    endtask

    task automatic readReg(input logic [1:0] a, input logic [31:0] exp, input string name);
        rdAddr = a;
        #1;
        checkOutput(name, rd_data, exp);
    endtask

    task automatic checkIrq(input logic expIrq, input logic [2:0] expId, input string name);
        checkOutput({name, "_irq"}, 32'(irq), 32'(expIrq));
        checkOutput({name, "_id"}, 32'(irq_id), 32'(expId));
    endtask

    task automatic checkAllZero(input string name);
        checkIrq(1'b0, 3'd0, name);
        for (int a = 0; a < 4; a++) readReg(2'(a), 32'd0, name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        idle();
        checkAllZero("in_reset");
        reset = 1'b1;
        idle();
        idle();
        checkAllZero("after_reset");

        writeReg(2'd0, 32'h05);
        pulse(8'h04);
        readReg(2'd1, 32'h04, "pend_src2");
        checkIrq(1'b1, 3'd2, "present_src2");
        applyStimulus(8'h00, 1'b1, 1'b0, 2'd0, 32'd0);
        checkIrq(1'b0, 3'd2, "accepted_src2");
        readReg(2'd3, 32'h8000_0002, "status_src2");
        readReg(2'd1, 32'h0, "pend_cleared_src2");
        writeReg(2'd2, 32'h0);
        readReg(2'd3, 32'h0000_0002, "status_after_eoi");

        writeReg(2'd0, 32'hFF);
        pulse(8'h22);
        checkIrq(1'b1, 3'd1, "priority_1_over_5");
        applyStimulus(8'h00, 1'b1, 1'b0, 2'd0, 32'd0);
        readReg(2'd3, 32'h8000_0001, "status_src1");
        idle();
        checkIrq(1'b0, 3'd1, "held_in_service");
        writeReg(2'd2, 32'h0);
        checkIrq(1'b1, 3'd5, "src5_after_eoi");
        applyStimulus(8'h00, 1'b1, 1'b0, 2'd0, 32'd0);
        writeReg(2'd2, 32'h0);
        checkIrq(1'b0, 3'd5, "drained");

        writeReg(2'd0, 32'h00);
        pulse(8'h08);
        readReg(2'd1, 32'h08, "masked_pending");
        checkOutput("masked_no_irq", 32'(irq), 32'd0);
        writeReg(2'd0, 32'h08);
        checkIrq(1'b1, 3'd3, "unmasked_src3");
        writeReg(2'd1, 32'h08);
        checkOutput("w1c_drops_irq", 32'(irq), 32'd0);
        readReg(2'd1, 32'h0, "w1c_pending");

        writeReg(2'd0, 32'h01);
        pulse(8'h01);
        applyStimulus(8'h01, 1'b0, 1'b0, 2'd0, 32'd0);
        idle();
        applyStimulus(8'h00, 1'b0, 1'b1, 2'd1, 32'h01);
        readReg(2'd1, 32'h01, "edge_beats_w1c");
        writeReg(2'd1, 32'h01);
        readReg(2'd1, 32'h00, "plain_w1c");

        pulse(8'h01);
        applyStimulus(8'h01, 1'b0, 1'b0, 2'd0, 32'd0);
        idle();
        applyStimulus(8'h00, 1'b1, 1'b0, 2'd0, 32'd0);
        readReg(2'd1, 32'h01, "edge_beats_accept");
        readReg(2'd3, 32'h8000_0000, "status_src0");
        writeReg(2'd2, 32'h0);
        checkIrq(1'b1, 3'd0, "src0_repended");

        applyStimulus(8'h00, 1'b1, 1'b0, 2'd0, 32'd0);
        pulse(8'h30);
        readReg(2'd1, 32'h30, "pend_before_reset");
        readReg(2'd3, 32'h8000_0000, "svc_before_reset");
        reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        idle();
        reset = 1'b1;
        idle();
        applyStimulus(8'h00, 1'b1, 1'b0, 2'd0, 32'd0);
        checkAllZero("taken_ignored");
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
